// File: rtl/ex_skid_queue_way0_pkg.sv
`default_nettype none
// ============================================================================
// Package     : du_ex_pkg
// Description : Field widths and packed decode->execute bundle for way0.
// Revision    : 1.0 - initial release
// ============================================================================
package du_ex_pkg;

  localparam int c_RD_ADDR_W = 5;
  localparam int c_PC_W      = 32;
  localparam int c_DATA_W    = 64;
  localparam int c_OPCODE_W  = 7;
  localparam int c_FUNCT3_W  = 3;
  localparam int c_FUNCT7_W  = 7;
  localparam int c_SHAMT_W   = 6;
  localparam int c_PID_W     = 2;

  // 255-bit bundle, field order fixed by the DU pipeline register
  typedef struct packed {
    logic [c_RD_ADDR_W-1:0] rdAddr;
    logic                   rdWriteEnable;
    logic [c_PC_W-1:0]      instAddr;
    logic [c_DATA_W-1:0]    rs1ReadData;
    logic [c_DATA_W-1:0]    rs2ReadData;
    logic [c_DATA_W-1:0]    imm;
    logic [c_OPCODE_W-1:0]  opCode;
    logic [c_FUNCT3_W-1:0]  funct3;
    logic [c_FUNCT7_W-1:0]  funct7;
    logic [c_SHAMT_W-1:0]   shamt;
    logic [c_PID_W-1:0]     way0_pID;
  } du_ex_bundle_t;

endpackage
`default_nettype wire

// File: rtl/ex_skid_queue_way0_if.sv
`default_nettype none
// ============================================================================
// Interface   : ex_skid_queue_way0_if
// Description : Upstream/downstream valid-ready bundle ports of the way0 queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_skid_queue_way0_if #(
  parameter int DEPTH = 2
);
  import du_ex_pkg::*;

  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic                   flush_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [c_RD_ADDR_W-1:0] rdAddr_i;
  logic                   rdWriteEnable_i;
  logic [c_PC_W-1:0]      instAddr_i;
  logic [c_DATA_W-1:0]    rs1ReadData_i;
  logic [c_DATA_W-1:0]    rs2ReadData_i;
  logic [c_DATA_W-1:0]    imm_i;
  logic [c_OPCODE_W-1:0]  opCode_i;
  logic [c_FUNCT3_W-1:0]  funct3_i;
  logic [c_FUNCT7_W-1:0]  funct7_i;
  logic [c_SHAMT_W-1:0]   shamt_i;
  logic [c_PID_W-1:0]     way0_pID_i;

  logic                   valid_o;
  logic                   ready_i;
  logic [c_RD_ADDR_W-1:0] rdAddr_o;
  logic                   rdWriteEnable_o;
  logic [c_PC_W-1:0]      instAddr_o;
  logic [c_DATA_W-1:0]    rs1ReadData_o;
  logic [c_DATA_W-1:0]    rs2ReadData_o;
  logic [c_DATA_W-1:0]    imm_o;
  logic [c_OPCODE_W-1:0]  opCode_o;
  logic [c_FUNCT3_W-1:0]  funct3_o;
  logic [c_FUNCT7_W-1:0]  funct7_o;
  logic [c_SHAMT_W-1:0]   shamt_o;
  logic [c_PID_W-1:0]     way0_pID_o;
  logic [c_CNT_W-1:0]     count_o;

  modport slave (
    input  flush_i, valid_i, rdAddr_i, rdWriteEnable_i, instAddr_i,
           rs1ReadData_i, rs2ReadData_i, imm_i, opCode_i, funct3_i,
           funct7_i, shamt_i, way0_pID_i, ready_i,
    output ready_o, valid_o, rdAddr_o, rdWriteEnable_o, instAddr_o,
           rs1ReadData_o, rs2ReadData_o, imm_o, opCode_o, funct3_o,
           funct7_o, shamt_o, way0_pID_o, count_o
  );

  modport master (
    output flush_i, valid_i, rdAddr_i, rdWriteEnable_i, instAddr_i,
           rs1ReadData_i, rs2ReadData_i, imm_i, opCode_i, funct3_i,
           funct7_i, shamt_i, way0_pID_i, ready_i,
    input  ready_o, valid_o, rdAddr_o, rdWriteEnable_o, instAddr_o,
           rs1ReadData_o, rs2ReadData_o, imm_o, opCode_o, funct3_o,
           funct7_o, shamt_o, way0_pID_o, count_o
  );

endinterface
`default_nettype wire

// File: rtl/ex_skid_queue_way0_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Pointers, occupancy and registered ready/valid for a DEPTH FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
  parameter int DEPTH   = 2,
  parameter int c_PTR_W = $clog2(DEPTH),
  parameter int c_CNT_W = $clog2(DEPTH) + 1
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic               flush_i,
  input  wire logic               valid_i,
  input  wire logic               ready_i,
  output logic                    push_o,
  output logic                    pop_o,
  output logic [c_PTR_W-1:0]      wptr_o,
  output logic [c_PTR_W-1:0]      rptr_o,
  output logic [c_CNT_W-1:0]      count_o,
  output logic                    ready_o,
  output logic                    valid_o
);

  logic [c_PTR_W-1:0] wptr_q, wptr_d;
  logic [c_PTR_W-1:0] rptr_q, rptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               w_push, w_pop;

  // Handshakes qualify only against the registered flags
  assign w_push = valid_i && ready_q && !flush_i;
  assign w_pop  = valid_q && ready_i && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) wptr_d = wptr_q + c_PTR_W'(1);
      if (w_pop)  rptr_d = rptr_q + c_PTR_W'(1);
      count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
    ready_d = (count_d < c_CNT_W'(DEPTH));
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign push_o  = w_push;
  assign pop_o   = w_pop;
  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;
  assign ready_o = ready_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/ex_skid_queue_way0.sv
`default_nettype none
// ============================================================================
// Module      : ex_skid_queue_way0
// Description : Registered-ready receive queue for the way0 decode->execute bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_skid_queue_way0
  import du_ex_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  ex_skid_queue_way0_if.slave   bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  du_ex_bundle_t        mem_q [DEPTH];
  du_ex_bundle_t        w_in_bundle;
  du_ex_bundle_t        w_head;
  logic                 w_push;
  logic                 w_pop;
  logic [c_PTR_W-1:0]   w_wptr;
  logic [c_PTR_W-1:0]   w_rptr;
  logic [c_CNT_W-1:0]   w_count;
  logic                 w_ready;
  logic                 w_valid;

  sync_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (bus.flush_i),
    .valid_i (bus.valid_i),
    .ready_i (bus.ready_i),
    .push_o  (w_push),
    .pop_o   (w_pop),
    .wptr_o  (w_wptr),
    .rptr_o  (w_rptr),
    .count_o (w_count),
    .ready_o (w_ready),
    .valid_o (w_valid)
  );

  always_comb begin
    w_in_bundle               = '0;
    w_in_bundle.rdAddr        = bus.rdAddr_i;
    w_in_bundle.rdWriteEnable = bus.rdWriteEnable_i;
    w_in_bundle.instAddr      = bus.instAddr_i;
    w_in_bundle.rs1ReadData   = bus.rs1ReadData_i;
    w_in_bundle.rs2ReadData   = bus.rs2ReadData_i;
    w_in_bundle.imm           = bus.imm_i;
    w_in_bundle.opCode        = bus.opCode_i;
    w_in_bundle.funct3        = bus.funct3_i;
    w_in_bundle.funct7        = bus.funct7_i;
    w_in_bundle.shamt         = bus.shamt_i;
    w_in_bundle.way0_pID      = bus.way0_pID_i;
  end

  // Entries are cleared on reset so the head mux reads zero afterwards
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_push) begin
      mem_q[w_wptr] <= w_in_bundle;
    end
  end

  assign w_head = mem_q[w_rptr];

  assign bus.ready_o         = w_ready;
  assign bus.valid_o         = w_valid;
  assign bus.count_o         = w_count;
  assign bus.rdAddr_o        = w_head.rdAddr;
  assign bus.rdWriteEnable_o = w_head.rdWriteEnable;
  assign bus.instAddr_o      = w_head.instAddr;
  assign bus.rs1ReadData_o   = w_head.rs1ReadData;
  assign bus.rs2ReadData_o   = w_head.rs2ReadData;
  assign bus.imm_o           = w_head.imm;
  assign bus.opCode_o        = w_head.opCode;
  assign bus.funct3_o        = w_head.funct3;
  assign bus.funct7_o        = w_head.funct7;
  assign bus.shamt_o         = w_head.shamt;
  assign bus.way0_pID_o      = w_head.way0_pID;

  logic w_unused;
  assign w_unused = w_pop;

endmodule
`default_nettype wire

// File: tb/tb_ex_skid_queue_way0.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_skid_queue_way0
// Description : Directed self-checking bench for ex_skid_queue_way0 (DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_skid_queue_way0;

  localparam int DEPTH = 2;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  ex_skid_queue_way0_if #(.DEPTH(DEPTH)) bus ();

  ex_skid_queue_way0 #(
    .DEPTH (DEPTH)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sampling happens 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input int id);
    bus.rdAddr_i        = 5'(id);
    bus.rdWriteEnable_i = 1'b1;
    bus.instAddr_i      = 32'h8000_0000 + 32'(id * 4);
    bus.rs1ReadData_i   = 64'hA5A5_0000_0000_0000 | 64'(id);
    bus.rs2ReadData_i   = 64'h5A5A_0000_0000_0000 | 64'(id);
    bus.imm_i           = 64'(id) << 4;
    bus.opCode_i        = 7'h33;
    bus.funct3_i        = 3'(id);
    bus.funct7_i        = 7'(id);
    bus.shamt_i         = 6'(id);
    bus.way0_pID_i      = 2'(id);
  endtask

  task automatic check_head(input string tag, input int id);
    check({tag, ".valid"}, 64'(bus.valid_o), 64'd1);
    check({tag, ".pc"},    64'(bus.instAddr_o), 64'(32'h8000_0000 + 32'(id * 4)));
    check({tag, ".rs2"},   bus.rs2ReadData_o, 64'h5A5A_0000_0000_0000 | 64'(id));
    check({tag, ".pid"},   64'(bus.way0_pID_o), 64'(id % 4));
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    reset_n           = 1'b0;
    bus.flush_i       = 1'b0;
    bus.valid_i       = 1'b0;
    bus.ready_i       = 1'b0;
    drive_pkt(0);

    // Reset state
    tick();
    tick();
    check("rst.valid", 64'(bus.valid_o), 64'd0);
    check("rst.ready", 64'(bus.ready_o), 64'd0);
    check("rst.count", 64'(bus.count_o), 64'd0);
    check("rst.pc",    64'(bus.instAddr_o), 64'd0);
    reset_n = 1'b1;
    tick();
    check("rst.ready_rise", 64'(bus.ready_o), 64'd1);

    // Single packet, immediate pop
    drive_pkt(5);
    bus.instAddr_i = 32'h8000_0000;
    bus.imm_i      = 64'h10;
    bus.valid_i    = 1'b1;
    bus.ready_i    = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    check("single.valid", 64'(bus.valid_o), 64'd1);
    check("single.pc",    64'(bus.instAddr_o), 64'h8000_0000);
    check("single.rd",    64'(bus.rdAddr_o), 64'd5);
    check("single.imm",   bus.imm_o, 64'h10);
    check("single.count", 64'(bus.count_o), 64'd1);
    tick();
    check("single.count0", 64'(bus.count_o), 64'd0);
    check("single.valid0", 64'(bus.valid_o), 64'd0);

    // Fill with A,B while C is held; then drain in order
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    drive_pkt(1);
    tick();
    check("fill.count1", 64'(bus.count_o), 64'd1);
    check("fill.ready1", 64'(bus.ready_o), 64'd1);
    drive_pkt(2);
    tick();
    check("fill.count2", 64'(bus.count_o), 64'd2);
    check("fill.ready0", 64'(bus.ready_o), 64'd0);
    drive_pkt(3);
    tick();
    check("hold.count", 64'(bus.count_o), 64'd2);
    check_head("hold.A", 1);
    // Full queue: pop and push offered together, push is blocked
    bus.ready_i = 1'b1;
    check("full.ready_low", 64'(bus.ready_o), 64'd0);
    tick();
    check("full.count1", 64'(bus.count_o), 64'd1);
    check("full.ready1", 64'(bus.ready_o), 64'd1);
    check_head("drain.B", 2);
    tick();
    bus.valid_i = 1'b0;
    check("drain.count", 64'(bus.count_o), 64'd1);
    check_head("drain.C", 3);
    tick();
    check("drain.empty", 64'(bus.count_o), 64'd0);
    check("drain.valid0", 64'(bus.valid_o), 64'd0);

    // Streaming 16 packets with pointer wrap
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    for (int k = 16; k < 32; k++) begin
      drive_pkt(k);
      tick();
      check("stream.count", 64'(bus.count_o), 64'd1);
      check_head("stream", k);
    end
    bus.valid_i = 1'b0;
    tick();
    check("stream.end", 64'(bus.count_o), 64'd0);

    // Flush with two buffered and one offered
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    drive_pkt(40);
    tick();
    drive_pkt(41);
    tick();
    check("flush.pre", 64'(bus.count_o), 64'd2);
    drive_pkt(42);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    check("flush.count", 64'(bus.count_o), 64'd0);
    check("flush.valid", 64'(bus.valid_o), 64'd0);
    check("flush.ready", 64'(bus.ready_o), 64'd1);
    tick();
    check("flush.still_empty", 64'(bus.valid_o), 64'd0);
    drive_pkt(43);
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b0;
    tick();
    bus.valid_i = 1'b0;
    check_head("flush.next", 43);
    check("flush.next_count", 64'(bus.count_o), 64'd1);

    // Reset while full
    drive_pkt(44);
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    check("rfull.count", 64'(bus.count_o), 64'd2);
    reset_n = 1'b0;
    tick();
    check("rfull.valid", 64'(bus.valid_o), 64'd0);
    check("rfull.ready", 64'(bus.ready_o), 64'd0);
    check("rfull.count0", 64'(bus.count_o), 64'd0);
    check("rfull.pc", 64'(bus.instAddr_o), 64'd0);
    check("rfull.imm", bus.imm_o, 64'd0);
    check("rfull.rs1", bus.rs1ReadData_o, 64'd0);
    reset_n = 1'b1;
    tick();
    check("rfull.ready_rise", 64'(bus.ready_o), 64'd1);
    check("rfull.valid_low", 64'(bus.valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_skid_queue_way0.md
# ex_skid_queue_way0

Execute-side receiver for the way0 decode→execute bundle. Accepts decoded instruction packets from the DU pipeline register over valid/ready, buffers up to DEPTH packets in a small circular queue, and presents the oldest packet to the way0 execute unit over a second valid/ready pair. Its ready output is registered, so the DU register can stall without a combinational ready path. Flush discards all buffered packets.

## Interface

Parameters:
- DEPTH, 2, number of buffered packets; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- flush_i  in  1  discard all buffered packets and any packet offered this cycle.
- valid_i  in  1  upstream packet valid.
- ready_o  out  1  registered; queue can accept a packet this cycle.
- rdAddr_i / rdWriteEnable_i / instAddr_i  in  5 / 1 / 32  destination register, write enable, PC.
- rs1ReadData_i / rs2ReadData_i / imm_i  in  64 each  operands and immediate.
- opCode_i / funct3_i / funct7_i / shamt_i / way0_pID_i  in  7 / 3 / 7 / 6 / 2  decode fields and packet ID.
- valid_o  out  1  registered; head packet valid toward execute.
- ready_i  in  1  execute accepts head packet.
- rdAddr_o … way0_pID_o  out  same widths as the inputs  head packet fields.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- push = valid_i && ready_o && !flush_i. pop = valid_o && ready_i && !flush_i.
- Storage: DEPTH-entry array of the bundle, write pointer wptr, read pointer rptr, both $clog2(DEPTH) bits, wrapping modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- push writes entry[wptr] and increments wptr. pop increments rptr.
- count_next = count + push − pop. Simultaneous push and pop leaves count unchanged and advances both pointers.
- Registered flags: ready_o <= (count_next < DEPTH) and valid_o <= (count_next != 0). Both are pure flops with no combinational input paths.
- Head fields are driven from entry[rptr] as a mux from storage. There is no combinational path from the inputs to the outputs.
- The full condition drops ready_o, so an offered packet is held upstream (the DU register keeps valid high). The empty condition drops valid_o, so a ready_i assertion is ignored.
- flush_i has priority over push and pop. Next edge: wptr=rptr=0, count=0, valid_o=0, ready_o=1, and the packet offered that cycle is dropped. Storage contents are unchanged.
- Reset, when reset_n is low at an edge: pointers=0, count=0, all storage entries=0, valid_o=0, ready_o=0, and every data output is 0. This takes priority over flush_i. ready_o rises at the first edge with reset_n high.

## Timing

- Latency: a packet pushed at edge N is visible on valid_o/data outputs after edge N, so it can be popped in cycle N+1. Minimum latency is one cycle. Throughput is 1 packet/cycle when not full.
- ready_o reflects state after the previous edge. With DEPTH=2, back-to-back pushes into an empty queue with ready_i=0 fill it. ready_o drops after the second push edge, and the third packet waits.
- Pop while full at edge N: ready_o=1 after edge N, and a push is possible in cycle N+1. There is no same-cycle full-through.
- Once valid_o is high, it and the head fields stay stable until pop or flush.
- Reset applied mid-operation loses all packets. There is no partial state.

## Structure

- Shared package (du_ex_pkg): typedef du_ex_bundle_t, a packed struct of rdAddr, rdWriteEnable, instAddr, rs1ReadData, rs2ReadData, imm, opCode, funct3, funct7, shamt and way0_pID (255 bits). The package also holds the field width constants.
- One sub-module, sync_fifo_ctrl: pointers, count, and registered ready/valid flags, parameterised by DEPTH. The top level holds the storage array, packs and unpacks the bundle, and applies flush.

## Test plan

- Reset, then a single packet (instAddr=32'h8000_0000, rdAddr=5, imm=64'h10) with ready_i=1 → valid_o=1 one cycle after push, fields match, count_o returns to 0 after pop.
- ready_i=0, three consecutive offers A, B, C with DEPTH=2 → A and B accepted, ready_o=0, C held. Then ready_i=1 → output order A, B, C, with no duplicates or drops.
- Streaming 16 packets with ready_i=1 and valid_i=1 → one packet per cycle, count_o stays at 1, and pointers wrap correctly (way0_pID cycling 0–3 observed in order).
- Queue full, pop and push presented in the same cycle → ready_o low that cycle so the push is blocked. After the edge, count_o=1 and ready_o=1.
- flush_i asserted with count_o=2 and valid_i=1 → next cycle count_o=0, valid_o=0, ready_o=1, and no flushed packet ever appears on the output.
- reset_n low for one edge with the queue full → valid_o=0, ready_o=0, and all outputs 0. The next edge gives ready_o=1.
